// File: rtl/csr_fifo_param.sv
// rtl/csr_fifo_param.sv - CSR-fed parametrised transmit FIFO with status, watermark and flush
// Optional FIFO_IRQ_EN adds irq_o plus STATUS[27] enable / STATUS[26] pending.
module csr_fifo_param #(
    parameter int          WIDTH    = 8,
    parameter int          DEPTH    = 16,
    parameter logic [11:0] CSR_BASE = 12'h800
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             csr_enable,
    input  logic [11:0]      csr_addr,
    input  logic [1:0]       csr_op,
    input  logic [31:0]      rs1_data,
    output logic [31:0]      csr_data_out,
    input  logic             next,
    output logic [WIDTH-1:0] data,
    output logic             have_next,
`ifdef FIFO_IRQ_EN
    output logic             irq_o,
`endif
    output logic             watermark
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]    r_count, r_thresh;
    logic             r_overflow, r_watermark;
    logic             r_irq_en, r_irq_pend;

    logic             w_strobe, w_sel_data, w_sel_status, w_sel_thresh;
    logic             w_empty, w_full, w_push_req, w_push, w_pop, w_drop, w_flush;
    logic             w_st_wr, w_irq_set;
    logic [31:0]      w_status_rd;
    logic [3:0]       w_st_old, w_st_new;
    logic [CW-1:0]    w_thresh_new, w_thresh_nxt, w_count_nxt;
    logic             w_wm_nxt;

    assign w_strobe     = csr_enable && (csr_op != 2'b00);
    assign w_sel_data   = csr_enable && (csr_addr == CSR_BASE);
    assign w_sel_status = csr_enable && (csr_addr == CSR_BASE + 12'd1);
    assign w_sel_thresh = csr_enable && (csr_addr == CSR_BASE + 12'd2);
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CW'(DEPTH));

`ifdef FIFO_IRQ_EN
    assign w_st_old = {r_overflow, 1'b0, r_irq_en, r_irq_pend};
`else
    assign w_st_old = {r_overflow, 3'b000};
`endif

    // Only STATUS bits 29..26 are writable; bit 28 always reads back as 0.
    always_comb begin
        w_st_new     = w_st_old;
        w_thresh_new = r_thresh;
        case (csr_op)
            2'b01: begin
                w_st_new     = rs1_data[29:26];
                w_thresh_new = rs1_data[CW-1:0];
            end
            2'b10: begin
                w_st_new     = w_st_old | rs1_data[29:26];
                w_thresh_new = r_thresh | rs1_data[CW-1:0];
            end
            2'b11: begin
                w_st_new     = w_st_old & ~rs1_data[29:26];
                w_thresh_new = r_thresh & ~rs1_data[CW-1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        w_status_rd         = '0;
        w_status_rd[CW-1:0] = r_count;
        w_status_rd[29]     = r_overflow;
        w_status_rd[30]     = w_full;
        w_status_rd[31]     = w_empty;
`ifdef FIFO_IRQ_EN
        w_status_rd[27]     = r_irq_en;
        w_status_rd[26]     = r_irq_pend;
`endif
    end

    always_comb begin
        csr_data_out = '0;
        if (w_sel_status)
            csr_data_out = w_status_rd;
        else if (w_sel_thresh)
            csr_data_out = {{(32-CW){1'b0}}, r_thresh};
    end

    assign w_st_wr      = w_strobe && w_sel_status;
    assign w_flush      = w_st_wr && w_st_new[2];
    assign w_push_req   = w_strobe && w_sel_data;
    assign w_pop        = next && !w_empty && !w_flush;
    assign w_push       = w_push_req && (!w_full || w_pop);
    assign w_drop       = w_push_req && w_full && !w_pop;
    assign w_count_nxt  = w_flush ? '0 :
                          r_count + CW'(w_push) - CW'(w_pop);
    assign w_thresh_nxt = (w_strobe && w_sel_thresh) ? w_thresh_new : r_thresh;
    assign w_wm_nxt     = (w_count_nxt >= w_thresh_nxt);
    assign w_irq_set    = (w_push && !w_pop && (r_count < r_thresh) && (w_count_nxt >= r_thresh))
                          || w_drop;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_thresh    <= CW'(DEPTH / 2);
            r_overflow  <= 1'b0;
            r_watermark <= 1'b0;
        end else begin
            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_count     <= w_count_nxt;
            r_thresh    <= w_thresh_nxt;
            r_watermark <= w_wm_nxt;
            if (w_st_wr && !w_st_new[3])
                r_overflow <= 1'b0;
            else if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    // Storage is deliberately not reset; data is gated to 0 while empty.
    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wr_ptr] <= rs1_data[WIDTH-1:0];
    end

`ifdef FIFO_IRQ_EN
    logic w_en_nxt, w_pend_nxt, r_irq;

    assign w_en_nxt   = w_st_wr ? w_st_new[1] : r_irq_en;
    assign w_pend_nxt = w_irq_set ? 1'b1 : ((w_st_wr && !w_st_new[0]) ? 1'b0 : r_irq_pend);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_irq_en   <= 1'b0;
            r_irq_pend <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_irq_en   <= w_en_nxt;
            r_irq_pend <= w_pend_nxt;
            r_irq      <= w_en_nxt && w_pend_nxt;
        end
    end
    assign irq_o = r_irq;
`else
    assign r_irq_en   = 1'b0;
    assign r_irq_pend = 1'b0;
`endif

    assign have_next = !w_empty;
    assign data      = w_empty ? '0 : r_mem[r_rd_ptr];
    assign watermark = r_watermark;
endmodule

// File: tb/tb_csr_fifo_param.sv
// tb/tb_csr_fifo_param.sv - self-checking bench for csr_fifo_param against a queue model
module tb_csr_fifo_param;
    localparam int          WIDTH = 8;
    localparam int          DEPTH = 16;
    localparam logic [11:0] BASE  = 12'h800;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b1;
    logic             csr_enable = 1'b0;
    logic [11:0]      csr_addr = '0;
    logic [1:0]       csr_op = '0;
    logic [31:0]      rs1_data = '0;
    logic [31:0]      csr_data_out;
    logic             next = 1'b0;
    logic [WIDTH-1:0] data;
    logic             have_next;
    logic             watermark;
`ifdef FIFO_IRQ_EN
    logic             irq_o;
    localparam logic [31:0] ST_MASK = 32'hF3FF_FFFF;
`else
    localparam logic [31:0] ST_MASK = 32'hFFFF_FFFF;
`endif

    int checks = 0;
    int failures = 0;

    int q[$];
    bit m_ov;
    int m_thr;

    csr_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CSR_BASE(BASE)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .csr_enable(csr_enable), .csr_addr(csr_addr),
        .csr_op(csr_op), .rs1_data(rs1_data), .csr_data_out(csr_data_out), .next(next),
        .data(data), .have_next(have_next),
`ifdef FIFO_IRQ_EN
        .irq_o(irq_o),
`endif
        .watermark(watermark)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] m_new(input logic [1:0] op, input logic [31:0] old, input logic [31:0] v);
        case (op)
            2'b01:   return v;
            2'b10:   return old | v;
            2'b11:   return old & ~v;
            default: return old;
        endcase
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(q.size());
        s[29] = m_ov;
        s[30] = (q.size() == DEPTH);
        s[31] = (q.size() == 0);
        return s;
    endfunction

    function automatic logic [31:0] m_read();
        if (!csr_enable) return 32'h0;
        if (csr_addr == BASE + 12'd1) return m_status();
        if (csr_addr == BASE + 12'd2) return 32'(m_thr);
        return 32'h0;
    endfunction

    function automatic void m_reset();
        q.delete();
        m_ov  = 1'b0;
        m_thr = DEPTH / 2;
    endfunction

    function automatic void m_update();
        bit pop_ok, wr;
        logic [31:0] nv;
        pop_ok = next && (q.size() > 0);
        wr     = csr_enable && (csr_op != 2'b00);
        if (wr && csr_addr == BASE) begin
            if (q.size() < DEPTH || pop_ok) begin
                if (pop_ok) void'(q.pop_front());
                q.push_back(int'(rs1_data[WIDTH-1:0]));
            end else begin
                m_ov = 1'b1;
            end
        end else if (wr && csr_addr == BASE + 12'd1) begin
            nv = m_new(csr_op, {2'b00, m_ov, 29'h0}, rs1_data);
            if (!nv[29]) m_ov = 1'b0;
            if (nv[28]) q.delete();
            else if (pop_ok) void'(q.pop_front());
        end else begin
            if (wr && csr_addr == BASE + 12'd2)
                m_thr = int'(m_new(csr_op, 32'(m_thr), rs1_data) & 32'h1F);
            if (pop_ok) void'(q.pop_front());
        end
    endfunction

    task automatic set_in(input logic en, input logic [11:0] a, input logic [1:0] op,
                          input logic [31:0] v, input logic nx);
        csr_enable = en;
        csr_addr   = a;
        csr_op     = op;
        rs1_data   = v;
        next       = nx;
    endtask

    task automatic tick();
        @(posedge clk_i);
        m_update();
        @(negedge clk_i);
        set_in(1'b0, 12'h0, 2'b00, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) @(negedge clk_i);
        m_reset();
        checks++; if (have_next !== 1'b0) begin failures++; $display("FAIL reset_have_next got %b want 0", have_next); end
        checks++; if (watermark !== 1'b0) begin failures++; $display("FAIL reset_watermark got %b want 0", watermark); end
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got %h want 00", data); end
        reset_i = 1'b0;
        set_in(1'b1, BASE + 12'd1, 2'b00, 32'h0, 1'b0); #1;
        checks++; if (csr_data_out !== 32'h8000_0000) begin failures++; $display("FAIL reset_status got %h want 80000000", csr_data_out); end
        set_in(1'b1, BASE + 12'd2, 2'b00, 32'h0, 1'b0); #1;
        checks++; if (csr_data_out !== 32'h8) begin failures++; $display("FAIL reset_thresh got %h want 8", csr_data_out); end
        set_in(1'b1, BASE, 2'b00, 32'h0, 1'b0); #1;
        checks++; if (csr_data_out !== 32'h0) begin failures++; $display("FAIL data_read got %h want 0", csr_data_out); end
        set_in(1'b0, 12'h0, 2'b00, 32'h0, 1'b0);
    endtask

    task automatic test_single();
        set_in(1'b1, BASE, 2'b01, 32'h142, 1'b0); tick();
        checks++; if (data !== 8'h42 || have_next !== 1'b1) begin failures++; $display("FAIL single_push got data=%h hn=%b want 42/1", data, have_next); end
        set_in(1'b1, BASE + 12'd1, 2'b00, 32'h0, 1'b0); #1;
        checks++; if (csr_data_out !== 32'h1) begin failures++; $display("FAIL single_count got %h want 1", csr_data_out); end
        set_in(1'b0, 12'h0, 2'b00, 32'h0, 1'b1); tick();
        checks++; if (have_next !== 1'b0 || data !== 8'h00) begin failures++; $display("FAIL single_pop got hn=%b data=%h want 0/00", have_next, data); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i <= 16; i++) begin set_in(1'b1, BASE, 2'b01, 32'(i), 1'b0); tick(); end
        set_in(1'b1, BASE + 12'd1, 2'b00, 32'h0, 1'b0); #1;
        checks++; if (csr_data_out !== 32'h6000_0010) begin failures++; $display("FAIL ovf_status got %h want 60000010", csr_data_out); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (data !== 8'(i) || have_next !== 1'b1) begin failures++; $display("FAIL ovf_order[%0d] got %h want %h", i, data, 8'(i)); end
            set_in(1'b0, 12'h0, 2'b00, 32'h0, 1'b1); tick();
        end
        set_in(1'b1, BASE + 12'd1, 2'b00, 32'h0, 1'b0); #1;
        checks++; if (csr_data_out !== 32'hA000_0000) begin failures++; $display("FAIL ovf_sticky got %h want a0000000", csr_data_out); end
        set_in(1'b1, BASE + 12'd1, 2'b11, 32'h2000_0000, 1'b0); tick();
        set_in(1'b1, BASE + 12'd1, 2'b00, 32'h0, 1'b0); #1;
        checks++; if (csr_data_out !== 32'h8000_0000) begin failures++; $display("FAIL ovf_clear got %h want 80000000", csr_data_out); end
        set_in(1'b0, 12'h0, 2'b00, 32'h0, 1'b0);
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) begin set_in(1'b1, BASE, 2'b10, 32'h10 + 32'(i), 1'b0); tick(); end
        set_in(1'b1, BASE, 2'b01, 32'hAA, 1'b1); tick();
        set_in(1'b1, BASE + 12'd1, 2'b00, 32'h0, 1'b0); #1;
        checks++; if (csr_data_out !== 32'h4000_0010) begin failures++; $display("FAIL full_pushpop_status got %h want 40000010", csr_data_out); end
        for (int k = 0; k < 16; k++) begin
            checks++; if (data !== ((k < 15) ? 8'h11 + 8'(k) : 8'hAA)) begin failures++; $display("FAIL full_pushpop_order[%0d] got %h want %h", k, data, (k < 15) ? 8'h11 + 8'(k) : 8'hAA); end
            set_in(1'b0, 12'h0, 2'b00, 32'h0, 1'b1); tick();
        end
        checks++; if (have_next !== 1'b0) begin failures++; $display("FAIL full_pushpop_empty got %b want 0", have_next); end
    endtask

    task automatic test_watermark();
        set_in(1'b1, BASE + 12'd2, 2'b01, 32'h3, 1'b0); tick();
        set_in(1'b1, BASE + 12'd2, 2'b00, 32'h0, 1'b0); #1;
        checks++; if (csr_data_out !== 32'h3) begin failures++; $display("FAIL thresh_rw got %h want 3", csr_data_out); end
        for (int k = 1; k <= 3; k++) begin
            set_in(1'b1, BASE, 2'b01, 32'(k), 1'b0); tick();
            checks++; if (watermark !== (k >= 3)) begin failures++; $display("FAIL wm_push[%0d] got %b want %b", k, watermark, k >= 3); end
        end
        set_in(1'b0, 12'h0, 2'b00, 32'h0, 1'b1); tick();
        checks++; if (watermark !== 1'b0) begin failures++; $display("FAIL wm_pop got %b want 0", watermark); end
        set_in(1'b1, BASE + 12'd1, 2'b10, 32'h1000_0000, 1'b0); tick();
        set_in(1'b1, BASE + 12'd1, 2'b00, 32'h0, 1'b0); #1;
        checks++; if (csr_data_out !== 32'h8000_0000 || have_next !== 1'b0) begin failures++; $display("FAIL flush got %h hn=%b want 80000000/0", csr_data_out, have_next); end
        set_in(1'b1, BASE + 12'd2, 2'b01, 32'd20, 1'b0); tick();
        for (int k = 0; k < 16; k++) begin set_in(1'b1, BASE, 2'b01, 32'(k), 1'b0); tick(); end
        checks++; if (watermark !== 1'b0 || have_next !== 1'b1) begin failures++; $display("FAIL wm_above_depth got wm=%b hn=%b want 0/1", watermark, have_next); end
        set_in(1'b1, BASE + 12'd1, 2'b01, 32'h1000_0000, 1'b0); tick();
        set_in(1'b1, BASE + 12'd2, 2'b01, 32'd8, 1'b0); tick();
    endtask

`ifdef FIFO_IRQ_EN
    task automatic test_irq();
        set_in(1'b1, BASE + 12'd1, 2'b01, 32'h0800_0000, 1'b0); tick();
        set_in(1'b1, BASE + 12'd2, 2'b01, 32'h2, 1'b0); tick();
        set_in(1'b1, BASE, 2'b01, 32'h1, 1'b0); tick();
        checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL irq_early got %b want 0", irq_o); end
        set_in(1'b1, BASE, 2'b01, 32'h2, 1'b0); tick();
        checks++; if (irq_o !== 1'b1) begin failures++; $display("FAIL irq_set got %b want 1", irq_o); end
        set_in(1'b1, BASE + 12'd1, 2'b11, 32'h0400_0000, 1'b0); tick();
        checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL irq_clear got %b want 0", irq_o); end
        set_in(1'b1, BASE + 12'd1, 2'b01, 32'h1000_0000, 1'b0); tick();
        set_in(1'b1, BASE + 12'd2, 2'b01, 32'd8, 1'b0); tick();
    endtask
`endif

    task automatic test_random();
        logic [1:0]  op;
        logic [11:0] a;
        logic [31:0] v;
        int          sel;
        for (int it = 0; it < 600; it++) begin
            sel = int'($urandom_range(0, 9));
            a   = (sel < 5) ? BASE : (sel < 7) ? BASE + 12'd1 : (sel < 9) ? BASE + 12'd2 : BASE + 12'd3;
            op  = 2'($urandom_range(0, 3));
            v   = $urandom;
            if (a == BASE + 12'd1 && $urandom_range(0, 7) != 0) v[28] = 1'b0;
            if (a == BASE + 12'd2) v = 32'($urandom_range(0, 20));
            set_in($urandom_range(0, 9) != 0, a, op, v, $urandom_range(0, 1) == 1); #1;
            checks++; if ((csr_data_out & ST_MASK) !== m_read()) begin failures++; $display("FAIL rand_read[%0d] got %h want %h", it, csr_data_out & ST_MASK, m_read()); end
            tick();
            checks++; if (have_next !== (q.size() != 0)) begin failures++; $display("FAIL rand_have_next[%0d] got %b want %b", it, have_next, q.size() != 0); end
            checks++; if (data !== ((q.size() != 0) ? 8'(q[0]) : 8'h00)) begin failures++; $display("FAIL rand_data[%0d] got %h want %h", it, data, (q.size() != 0) ? 8'(q[0]) : 8'h00); end
            checks++; if (watermark !== (q.size() >= m_thr)) begin failures++; $display("FAIL rand_watermark[%0d] got %b want %b", it, watermark, q.size() >= m_thr); end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 10; k++) begin set_in(1'b1, BASE, 2'b01, 32'h55 + 32'(k), 1'b0); tick(); end
        set_in(1'b1, BASE + 12'd2, 2'b01, 32'd4, 1'b1);
        #2 reset_i = 1'b1;
        #1;
        m_reset();
        checks++; if (have_next !== 1'b0 || data !== 8'h00 || watermark !== 1'b0) begin failures++; $display("FAIL reset_mid got hn=%b data=%h wm=%b want 0/00/0", have_next, data, watermark); end
`ifdef FIFO_IRQ_EN
        checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL reset_mid_irq got %b want 0", irq_o); end
`endif
        @(negedge clk_i);
        reset_i = 1'b0;
        set_in(1'b1, BASE + 12'd1, 2'b00, 32'h0, 1'b0); #1;
        checks++; if (csr_data_out !== 32'h8000_0000) begin failures++; $display("FAIL reset_mid_status got %h want 80000000", csr_data_out); end
        set_in(1'b1, BASE + 12'd2, 2'b00, 32'h0, 1'b0); #1;
        checks++; if (csr_data_out !== 32'h8) begin failures++; $display("FAIL reset_mid_thresh got %h want 8", csr_data_out); end
        set_in(1'b0, 12'h0, 2'b00, 32'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_watermark();
`ifdef FIFO_IRQ_EN
        test_irq();
`endif
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
